// File: rtl/reg_file_scoreboard_pkg.sv
// ============================================================================
//  Module      : reg_file_scoreboard_pkg
//  Description : Shared widths, register count and types for the register
//                file with busy scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package reg_file_scoreboard_pkg;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREG   = 2 ** ADDR_W;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [ADDR_W:0]   count_t;

    localparam addr_t REG_ZERO = 5'd0;
endpackage

`default_nettype wire

// File: rtl/reg_file_scoreboard_if.sv
// ============================================================================
//  Module      : reg_file_scoreboard_if
//  Description : Write-back, read and issue signals of the register file.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface reg_file_scoreboard_if;
    import reg_file_scoreboard_pkg::*;

    logic  regwre;
    addr_t writereg;
    data_t writedata;
    addr_t readreg1;
    addr_t readreg2;
    data_t readdata1;
    data_t readdata2;
    logic  issuevalid;
    logic  users;
    logic  usert;
    addr_t issuedest;
    logic  stall;
    count_t pending;

    modport master (
        output regwre, writereg, writedata, readreg1, readreg2,
        output issuevalid, users, usert, issuedest,
        input  readdata1, readdata2, stall, pending
    );

    modport slave (
        input  regwre, writereg, writedata, readreg1, readreg2,
        input  issuevalid, users, usert, issuedest,
        output readdata1, readdata2, stall, pending
    );
endinterface

`default_nettype wire

// File: rtl/reg_file_scoreboard_busy_scoreboard.sv
// ============================================================================
//  Module      : busy_scoreboard
//  Description : Per-register busy bits, RAW/WAW stall and busy-count.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module busy_scoreboard
    import reg_file_scoreboard_pkg::*;
(
    input  wire logic   clk,
    input  wire logic   rst_n,
    input  wire logic   i_clr,
    input  wire addr_t  i_wr_addr,
    input  wire addr_t  i_rs,
    input  wire addr_t  i_rt,
    input  wire logic   i_issue_valid,
    input  wire logic   i_use_rs,
    input  wire logic   i_use_rt,
    input  wire addr_t  i_dest,
    output logic        o_stall,
    output count_t      o_pending
);
    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_busy_nxt;
    count_t          r_pending;
    logic            w_haz1;
    logic            w_haz2;
    logic            w_hazd;
    logic            w_set;
    logic            w_set_new;
    logic            w_clr_eff;

    // A write retiring this cycle resolves the hazard on its register.
    assign w_haz1 = r_busy[i_rs] && !(i_clr && i_wr_addr == i_rs);
    assign w_haz2 = r_busy[i_rt] && !(i_clr && i_wr_addr == i_rt);
    assign w_hazd = (i_dest != REG_ZERO) && r_busy[i_dest]
                    && !(i_clr && i_wr_addr == i_dest);

    assign o_stall = i_issue_valid
                     && ((i_use_rs && w_haz1) || (i_use_rt && w_haz2) || w_hazd);
    assign w_set   = i_issue_valid && !o_stall && (i_dest != REG_ZERO);

    // Set and clear of the same register cancel in the count: busy stays 1.
    assign w_set_new = w_set && !r_busy[i_dest];
    assign w_clr_eff = i_clr && r_busy[i_wr_addr] && !(w_set && i_dest == i_wr_addr);

    always_comb begin
        w_busy_nxt = r_busy;
        if (i_clr)
            w_busy_nxt[i_wr_addr] = 1'b0;
        if (w_set)
            w_busy_nxt[i_dest] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy    <= '0;
            r_pending <= '0;
        end else begin
            r_busy    <= w_busy_nxt;
            r_pending <= r_pending + count_t'(w_set_new) - count_t'(w_clr_eff);
        end
    end

    assign o_pending = r_pending;
endmodule

`default_nettype wire

// File: rtl/reg_file_scoreboard.sv
// ============================================================================
//  Module      : reg_file_scoreboard
//  Description : 32x32 register file, two bypassed read ports, busy scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_file_scoreboard
    import reg_file_scoreboard_pkg::*;
(
    input  wire logic           clk,
    input  wire logic           rst_n,
    reg_file_scoreboard_if.slave bus
);
    data_t r_regs [NREG];
    logic  w_we;

    assign w_we = bus.regwre && (bus.writereg != REG_ZERO);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++)
                r_regs[i] <= '0;
        end else if (w_we) begin
            r_regs[bus.writereg] <= bus.writedata;
        end
    end

    // Write-through bypass; w_we already excludes register 0.
    assign bus.readdata1 = !rst_n ? '0
                         : (w_we && bus.writereg == bus.readreg1) ? bus.writedata
                         : r_regs[bus.readreg1];
    assign bus.readdata2 = !rst_n ? '0
                         : (w_we && bus.writereg == bus.readreg2) ? bus.writedata
                         : r_regs[bus.readreg2];

    busy_scoreboard u_busy_scoreboard (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_clr         (w_we),
        .i_wr_addr     (bus.writereg),
        .i_rs          (bus.readreg1),
        .i_rt          (bus.readreg2),
        .i_issue_valid (bus.issuevalid),
        .i_use_rs      (bus.users),
        .i_use_rt      (bus.usert),
        .i_dest        (bus.issuedest),
        .o_stall       (bus.stall),
        .o_pending     (bus.pending)
    );
endmodule

`default_nettype wire

// File: tb/tb_reg_file_scoreboard.sv
// ============================================================================
//  Module      : tb_reg_file_scoreboard
//  Description : Directed bench with a reference model of the register file.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_file_scoreboard;
    import reg_file_scoreboard_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    reg_file_scoreboard_if bus ();

    reg_file_scoreboard dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain arrays of data and busy flags.
    logic [31:0] m_regs [32];
    logic        m_busy [32];

    function automatic int m_popcount();
        int n = 0;
        for (int i = 0; i < 32; i++)
            n += int'(m_busy[i]);
        return n;
    endfunction

    function automatic logic m_retiring(input logic [4:0] a);
        return bus.regwre && bus.writereg != 0 && bus.writereg == a;
    endfunction

    function automatic logic m_stall();
        logic h1, h2, hd;
        h1 = m_busy[bus.readreg1] && !m_retiring(bus.readreg1);
        h2 = m_busy[bus.readreg2] && !m_retiring(bus.readreg2);
        hd = bus.issuedest != 0 && m_busy[bus.issuedest] && !m_retiring(bus.issuedest);
        return bus.issuevalid && ((bus.users && h1) || (bus.usert && h2) || hd);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (!rst_n || a == 0) return 32'd0;
        if (m_retiring(a))    return bus.writedata;
        return m_regs[a];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                m_regs[i] <= 32'd0;
                m_busy[i] <= 1'b0;
            end
        end else begin : upd
            logic st;
            st = m_stall();
            if (bus.regwre && bus.writereg != 0) begin
                m_regs[bus.writereg] <= bus.writedata;
                if (!(bus.issuevalid && !st && bus.issuedest == bus.writereg))
                    m_busy[bus.writereg] <= 1'b0;
            end
            if (bus.issuevalid && !st && bus.issuedest != 0)
                m_busy[bus.issuedest] <= 1'b1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        check("model_rd1",     bus.readdata1, m_read(bus.readreg1));
        check("model_rd2",     bus.readdata2, m_read(bus.readreg2));
        check("model_stall",   32'(bus.stall), 32'(m_stall()));
        check("model_pending", 32'(bus.pending), 32'(m_popcount()));
    end

    task automatic idle();
        bus.regwre = 0; bus.writereg = 0; bus.writedata = 0;
        bus.readreg1 = 0; bus.readreg2 = 0;
        bus.issuevalid = 0; bus.users = 0; bus.usert = 0; bus.issuedest = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        settle();
        check("reset_pending", 32'(bus.pending), 32'd0);
        check("reset_stall",   32'(bus.stall), 32'd0);

        // Write then read back.
        bus.regwre = 1; bus.writereg = 5; bus.writedata = 32'hDEADBEEF;
        step(); idle(); bus.readreg1 = 5;
        settle();
        check("read_r5", bus.readdata1, 32'hDEADBEEF);
        check("r5_not_busy", 32'(bus.pending), 32'd0);

        // Writes to r0 are ignored.
        step();
        bus.regwre = 1; bus.writereg = 0; bus.writedata = 32'h1234; bus.readreg2 = 0;
        settle();
        check("r0_bypass", bus.readdata2, 32'd0);
        step(); idle();
        settle();
        check("r0_read", bus.readdata2, 32'd0);

        // Same-cycle bypass.
        step();
        bus.regwre = 1; bus.writereg = 7; bus.writedata = 32'hA5A5A5A5; bus.readreg2 = 7;
        settle();
        check("bypass_r7", bus.readdata2, 32'hA5A5A5A5);

        // RAW hazard on r3.
        step(); idle();
        bus.issuevalid = 1; bus.issuedest = 3;
        step(); idle();
        settle();
        check("raw_pending1", 32'(bus.pending), 32'd1);
        bus.issuevalid = 1; bus.users = 1; bus.readreg1 = 3;
        settle();
        check("raw_stall", 32'(bus.stall), 32'd1);
        step();
        bus.regwre = 1; bus.writereg = 3; bus.writedata = 32'h33;
        settle();
        check("raw_resolve", 32'(bus.stall), 32'd0);
        check("raw_rd1_bypass", bus.readdata1, 32'h33);
        step(); idle();
        settle();
        check("raw_pending0", 32'(bus.pending), 32'd0);

        // WAW and set-wins on r4.
        step();
        bus.issuevalid = 1; bus.issuedest = 4;
        step();
        settle();
        check("waw_stall", 32'(bus.stall), 32'd1);
        check("waw_pending1", 32'(bus.pending), 32'd1);
        step();
        bus.regwre = 1; bus.writereg = 4; bus.writedata = 32'h44;
        settle();
        check("waw_resolve", 32'(bus.stall), 32'd0);
        step(); idle();
        settle();
        check("setwins_pending", 32'(bus.pending), 32'd1);
        bus.issuevalid = 1; bus.issuedest = 4;
        settle();
        check("setwins_busy4", 32'(bus.stall), 32'd1);
        step(); idle();
        bus.regwre = 1; bus.writereg = 4; bus.writedata = 32'h45;
        step(); idle();
        settle();
        check("r4_retired", 32'(bus.pending), 32'd0);

        // Fill all 31 registers, then retire them.
        for (int d = 1; d < 32; d++) begin
            bus.issuevalid = 1; bus.issuedest = 5'(d);
            step();
        end
        idle();
        settle();
        check("fill_pending31", 32'(bus.pending), 32'd31);
        for (int d = 1; d < 32; d++) begin
            bus.regwre = 1; bus.writereg = 5'(d); bus.writedata = 32'(d * 3);
            step();
        end
        idle();
        settle();
        check("drain_pending0", 32'(bus.pending), 32'd0);
        bus.readreg1 = 31; bus.readreg2 = 9;
        settle();
        check("drain_r31", bus.readdata1, 32'd93);
        check("drain_r9",  bus.readdata2, 32'd27);

        // Spurious write-back to a non-busy register.
        step(); idle();
        bus.issuevalid = 1; bus.issuedest = 2;
        step(); idle();
        bus.regwre = 1; bus.writereg = 9; bus.writedata = 32'h99;
        step(); idle();
        settle();
        check("spurious_pending", 32'(bus.pending), 32'd1);

        // Reset asserted mid-operation with an in-flight write.
        step();
        bus.issuevalid = 1; bus.issuedest = 6;
        bus.regwre = 1; bus.writereg = 12; bus.writedata = 32'hCAFEF00D;
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_pending", 32'(bus.pending), 32'd0);
        check("midreset_stall", 32'(bus.stall), 32'd0);
        for (int a = 0; a < 32; a++) begin
            bus.readreg1 = 5'(a); bus.readreg2 = 5'(31 - a);
            #0.1;
            check("midreset_rd1", bus.readdata1, 32'd0);
            check("midreset_rd2", bus.readdata2, 32'd0);
        end
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        bus.readreg1 = 12; bus.readreg2 = 9;
        settle();
        check("postreset_r12", bus.readdata1, 32'd0);
        check("postreset_r9",  bus.readdata2, 32'd0);
        check("postreset_pending", 32'(bus.pending), 32'd0);
        step(); idle();
        repeat (2) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
